// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, RV32I
// width codes and the access-size decode used by the range check.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Illegal codes fall through to 4; they are flagged as errors elsewhere.
  function automatic logic [2:0] access_size(input logic [2:0] funct3);
    logic [2:0] size;
    case (funct3)
      F3_B, F3_BU: size = 3'd1;
      F3_H, F3_HU: size = 3'd2;
      default:     size = 3'd4;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering between the execute-stage view (right-justified data)
// and the big-endian dmem port, in both directions. Purely combinational.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_mem_dout,
  output logic [31:0] o_mem_din,
  output logic [2:0]  o_we_mask,
  output logic [31:0] o_rdata
);

  // Lowest address sits in the MSB lane, so narrow stores shift up.
  always_comb begin
    o_mem_din = i_wdata;
    o_we_mask = 3'b000;
    case (i_funct3)
      F3_B: begin
        o_mem_din = {i_wdata[7:0], 24'h0};
        o_we_mask = 3'b001;
      end
      F3_H: begin
        o_mem_din = {i_wdata[15:0], 16'h0};
        o_we_mask = 3'b011;
      end
      F3_W: begin
        o_mem_din = i_wdata;
        o_we_mask = 3'b111;
      end
      default: begin
        o_mem_din = i_wdata;
        o_we_mask = 3'b000;
      end
    endcase
  end

  always_comb begin
    o_rdata = i_mem_dout;
    case (i_funct3)
      F3_B:    o_rdata = {{24{i_mem_dout[31]}}, i_mem_dout[31:24]};
      F3_H:    o_rdata = {{16{i_mem_dout[31]}}, i_mem_dout[31:16]};
      F3_BU:   o_rdata = {24'h0, i_mem_dout[31:24]};
      F3_HU:   o_rdata = {16'h0, i_mem_dout[31:16]};
      default: o_rdata = i_mem_dout;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit in front of dmem port 1: one request in flight, latched at
// accept, performed in ACCESS, returned in RESP with back-to-back accept.
module lsu
  import lsu_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 4096,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  mem_we0,
  output logic                  mem_we1,
  output logic                  mem_we2,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  state_t                r_state;
  state_t                w_next;
  logic                  r_we;
  logic [2:0]            r_funct3;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_rsp_err;

  logic                  w_req_ready;
  logic                  w_accept;
  logic [2:0]            w_size;
  logic [32:0]           w_end;
  logic                  w_bad_f3;
  logic                  w_req_err;
  logic [DATA_WIDTH-1:0] w_din;
  logic [2:0]            w_we_mask;
  logic [DATA_WIDTH-1:0] w_ext;
  logic                  w_do_write;

  // Error is resolved at accept so ACCESS only needs the latched flag.
  assign w_size    = access_size(req_funct3);
  assign w_end     = {1'b0, req_addr} + {30'b0, w_size};
  assign w_bad_f3  = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                     (req_funct3 == 3'b111);
  assign w_req_err = w_bad_f3 || (req_we && req_funct3[2]) ||
                     (w_end > 33'(DEPTH));

  always_comb begin
    w_next      = r_state;
    w_req_ready = 1'b0;
    case (r_state)
      IDLE: begin
        w_req_ready = rst_n;
        if (req_valid) w_next = ACCESS;
      end
      ACCESS: begin
        w_next = RESP;
      end
      RESP: begin
        w_req_ready = rst_n && rsp_ready;
        if (rsp_ready) w_next = req_valid ? ACCESS : IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  assign w_accept = req_valid && w_req_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_we      <= 1'b0;
      r_funct3  <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_err     <= 1'b0;
      r_rdata   <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we     <= req_we;
        r_funct3 <= req_funct3;
        r_addr   <= req_addr[ADDR_WIDTH-1:0];
        r_wdata  <= req_wdata;
        r_err    <= w_req_err;
      end
      if (r_state == ACCESS) begin
        r_rdata   <= (!r_we && !r_err) ? w_ext : '0;
        r_rsp_err <= r_err;
      end
    end
  end

  lsu_align u_align (
    .i_funct3   (r_funct3),
    .i_wdata    (r_wdata),
    .i_mem_dout (mem_dout),
    .o_mem_din  (w_din),
    .o_we_mask  (w_we_mask),
    .o_rdata    (w_ext)
  );

  // Gating with rst_n keeps a reset that lands in ACCESS from writing.
  assign w_do_write = rst_n && (r_state == ACCESS) && r_we && !r_err;

  assign {mem_we2, mem_we1, mem_we0} = w_do_write ? w_we_mask : 3'b000;
  assign mem_addr  = r_addr;
  assign mem_din   = w_din;
  assign req_ready = w_req_ready;
  assign rsp_valid = (r_state == RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu with a byte-addressed dmem model on port 1.
module tb_lsu;
  import lsu_pkg::*;

  localparam int DEPTH = 4096;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [2:0]    req_funct3 = 3'b000;
  logic [31:0]   req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_din;
  logic          mem_we0, mem_we1, mem_we2;
  logic [31:0]   mem_dout;

  always #5 clk = ~clk;

  lsu #(.DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_we0    (mem_we0),
    .mem_we1    (mem_we1),
    .mem_we2    (mem_we2),
    .mem_dout   (mem_dout)
  );

  // dmem model: we0 -> addr, we1 -> addr+1, we2 -> addr+2 and addr+3
  logic [7:0]    dmem    [DEPTH];
  logic [7:0]    ref_mem [DEPTH];
  logic [AW-1:0] a1, a2, a3;
  assign a1 = mem_addr + AW'(1);
  assign a2 = mem_addr + AW'(2);
  assign a3 = mem_addr + AW'(3);
  assign mem_dout = {dmem[mem_addr], dmem[a1], dmem[a2], dmem[a3]};

  always @(posedge clk) begin
    if (mem_we0) dmem[mem_addr] <= mem_din[31:24];
    if (mem_we1) dmem[a1] <= mem_din[23:16];
    if (mem_we2) begin
      dmem[a2] <= mem_din[15:8];
      dmem[a3] <= mem_din[7:0];
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       tag;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   we_cycles = 0;
  logic [2:0]  we_mask = '0;
  logic [31:0] we_din = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: byte-wise memory image and RV32I extension rules.
  task automatic model_push(input logic we, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input string tag);
    exp_t        e;
    int          sz;
    int          a;
    logic [32:0] end_a;
    logic [31:0] w;
    sz    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    end_a = {1'b0, addr} + 33'(sz);
    e.err = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) ||
            (we && f3[2]) || (end_a > 33'(DEPTH));
    e.rdata = '0;
    e.tag   = tag;
    a = int'(addr % DEPTH);
    if (!e.err) begin
      if (we) begin
        if (sz == 1) ref_mem[a] = wdata[7:0];
        else if (sz == 2) begin
          ref_mem[a] = wdata[15:8];
          ref_mem[(a + 1) % DEPTH] = wdata[7:0];
        end else begin
          ref_mem[a] = wdata[31:24];
          ref_mem[(a + 1) % DEPTH] = wdata[23:16];
          ref_mem[(a + 2) % DEPTH] = wdata[15:8];
          ref_mem[(a + 3) % DEPTH] = wdata[7:0];
        end
      end else begin
        w = {ref_mem[a], ref_mem[(a + 1) % DEPTH],
             ref_mem[(a + 2) % DEPTH], ref_mem[(a + 3) % DEPTH]};
        case (f3)
          3'b000:  e.rdata = {{24{w[31]}}, w[31:24]};
          3'b001:  e.rdata = {{16{w[31]}}, w[31:16]};
          3'b100:  e.rdata = {24'h0, w[31:24]};
          3'b101:  e.rdata = {16'h0, w[31:16]};
          default: e.rdata = w;
        endcase
      end
    end
    sb_q.push_back(e);
  endtask

  // Returns at posedge+1 after the accepting edge (DUT then in ACCESS).
  task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, input string tag);
    int n = 0;
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    #1;
    while (!req_ready && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      check({tag, "_accept_timeout"}, 32'(req_ready), 32'd1);
      req_valid = 1'b0;
    end else begin
      model_push(we, f3, addr, wdata, tag);
      @(posedge clk); #1;
      req_valid = 1'b0;
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk); #2;
      n++;
    end
    check({tag, "_drain"}, 32'(sb_q.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if ({mem_we2, mem_we1, mem_we0} != 3'b000) begin
      we_cycles++;
      we_mask = {mem_we2, mem_we1, mem_we0};
      we_din  = mem_din;
    end
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check({e.tag, "_rdata"}, rsp_rdata, e.rdata);
        check({e.tag, "_err"}, 32'(rsp_err), 32'(e.err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          n;
    logic [7:0]  b;
    logic [7:0]  saved;
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom);
      dmem[i] = b;
      ref_mem[i] = b;
    end

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err",   32'(rsp_err), 32'd0);
    check("rst_mem_addr",  32'(mem_addr), 32'd0);
    check("rst_mem_din",   mem_din, 32'd0);
    check("rst_mem_we",    32'({mem_we2, mem_we1, mem_we0}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // word store/load with latency check
    we_cycles = 0;
    send(1'b1, F3_W, 32'h10, 32'hDEADBEEF, "sw");
    check("sw_lat_access", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    check("sw_lat_resp", 32'(rsp_valid), 32'd1);
    drain("sw");
    check("sw_we_cycles", 32'(we_cycles), 32'd1);
    check("sw_we_mask", 32'(we_mask), 32'd7);
    check("sw_din", we_din, 32'hDEADBEEF);
    send(1'b0, F3_W, 32'h10, 32'h0, "lw");
    drain("lw");

    // byte store, signed and unsigned loads
    we_cycles = 0;
    send(1'b1, F3_B, 32'h21, 32'h12345680, "sb");
    drain("sb");
    check("sb_we_cycles", 32'(we_cycles), 32'd1);
    check("sb_we_mask", 32'(we_mask), 32'd1);
    check("sb_din", we_din, 32'h80000000);
    send(1'b0, F3_B,  32'h21, 32'h0, "lb");
    send(1'b0, F3_BU, 32'h21, 32'h0, "lbu");
    drain("lb");

    // half store, signed and unsigned loads
    we_cycles = 0;
    send(1'b1, F3_H, 32'h30, 32'h00008001, "sh");
    drain("sh");
    check("sh_we_cycles", 32'(we_cycles), 32'd1);
    check("sh_we_mask", 32'(we_mask), 32'd3);
    check("sh_din", we_din, 32'h80010000);
    send(1'b0, F3_H,  32'h30, 32'h0, "lh");
    send(1'b0, F3_HU, 32'h30, 32'h0, "lhu");
    drain("lh");

    // error cases and range boundary
    we_cycles = 0;
    send(1'b0, F3_W,   32'(DEPTH - 2), 32'h0, "lw_oob");
    send(1'b1, F3_HU,  32'h40, 32'hCAFEF00D, "st_f3_101");
    send(1'b1, F3_W,   32'(DEPTH - 1), 32'h11223344, "sw_oob");
    send(1'b0, 3'b011, 32'h40, 32'h0, "ld_f3_011");
    send(1'b0, F3_W,   32'hFFFF_FFFE, 32'h0, "lw_wrap");
    send(1'b0, F3_B,   32'(DEPTH - 1), 32'h0, "lb_last");
    send(1'b0, F3_W,   32'(DEPTH - 4), 32'h0, "lw_last");
    drain("err");
    check("err_we_cycles", 32'(we_cycles), 32'd0);

    // response back-pressure with a pending request
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    send(1'b0, F3_W, 32'h10, 32'h0, "stall_lw");
    req_we = 1'b0; req_funct3 = F3_BU; req_addr = 32'h21; req_wdata = '0;
    req_valid = 1'b1;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    check("stall_rsp_seen", 32'(rsp_valid), 32'd1);
    repeat (5) begin
      @(negedge clk); #1;
      check("stall_valid", 32'(rsp_valid), 32'd1);
      check("stall_rdata", rsp_rdata, sb_q[0].rdata);
      check("stall_err", 32'(rsp_err), 32'(sb_q[0].err));
      check("stall_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    check("release_req_ready", 32'(req_ready), 32'd1);
    model_push(1'b0, F3_BU, 32'h21, 32'h0, "stall_lbu");
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("release_in_access", 32'(req_ready), 32'd0);
    check("release_rsp_valid", 32'(rsp_valid), 32'd0);
    drain("stall");

    // reset during the ACCESS of a store
    send(1'b1, F3_B, 32'h50, 32'h00000011, "sb_pre");
    drain("sb_pre");
    saved = ref_mem[32'h50];
    we_cycles = 0;
    send(1'b1, F3_B, 32'h50, 32'h000000AA, "sb_rst");
    rst_n = 1'b0;
    sb_q.delete();
    ref_mem[32'h50] = saved;
    #1;
    check("rst_access_we", 32'({mem_we2, mem_we1, mem_we0}), 32'd0);
    @(negedge clk); #1;
    check("rst_access_we_cycles", 32'(we_cycles), 32'd0);
    @(posedge clk); @(negedge clk); #1;
    check("rst_access_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_access_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(1'b0, F3_BU, 32'h50, 32'h0, "lbu_after_rst");
    drain("rst");
    check("rst_total_we_cycles", 32'(we_cycles), 32'd0);

    // back-to-back mixed traffic
    for (int i = 0; i < 8; i++) begin
      send(1'b1, F3_W, 32'(32'h100 + 4 * i), $urandom, "b2b_sw");
    end
    for (int i = 0; i < 8; i++) begin
      send(1'b0, (i % 2 == 0) ? F3_H : F3_BU, 32'(32'h100 + 3 * i), 32'h0, "b2b_ld");
    end
    drain("b2b");

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit directly upstream of `dmem`. It accepts one load or store request at a time from the execute stage over a valid/ready handshake, drives `dmem`'s second port (`addr1`, `din`, `we0..we2`, `dout1`), packs store data into the memory's big-endian byte lanes, and sign- or zero-extends load data. Each result is returned over a second valid/ready handshake, with an error flag for illegal or out-of-range accesses.

## Interface
- `DATA_WIDTH`, default 32: data width. Only 32 is supported.
- `DEPTH`, default 4096: `dmem` depth in bytes. `ADDR_WIDTH` is a localparam equal to `$clog2(DEPTH)`.
- Clocking: one clock; reset is synchronous and active-low.
- `clk` in 1: clock. All state changes on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when high together with `req_valid`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I width code. 000 b, 001 h, 010 w, 100 bu, 101 hu.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response consumed.
- `rsp_rdata` out 32: extended load data; 0 for stores and errors.
- `rsp_err` out 1: illegal funct3 or out-of-range address.
- `mem_addr` out ADDR_WIDTH: connects to `dmem.addr1`.
- `mem_din` out 32: connects to `dmem.din`.
- `mem_we0`, `mem_we1`, `mem_we2` out 1 each: connect to `dmem.we0..we2`.
- `mem_dout` in 32: connects to `dmem.dout1` (asynchronous read).

## Operation
- State machine states: IDLE, ACCESS, RESP.
  - IDLE: `req_ready=1`. On handshake, latch `we`, `funct3`, `addr`, `wdata` and the computed error, then go to ACCESS.
  - ACCESS: `req_ready=0`. Drive `mem_addr` from the latched address.
    - Store without error: assert write enables for this single cycle.
    - Load: register the extended `mem_dout` into `rsp_rdata`.
    - Always go to RESP.
  - RESP: `rsp_valid=1`.
    - `req_ready = rsp_ready`.
    - If `rsp_ready` and `req_valid`, accept the next request and go to ACCESS.
    - If `rsp_ready` alone, go to IDLE.
    - Otherwise hold; all response outputs stay stable.
- Store packing (byte at the lowest address is the MSB):
  - sb: `mem_din = {wdata[7:0], 24'h0}`, `we0` only.
  - sh: `mem_din = {wdata[15:0], 16'h0}`, `we0` and `we1`.
  - sw: `mem_din = wdata`, `we0`, `we1` and `we2`.
- Load extension:
  - lb: sign-extend `mem_dout[31:24]`.
  - lh: sign-extend `mem_dout[31:16]`.
  - lw: pass `mem_dout` unchanged.
  - lbu / lhu: zero-extend the same fields as lb / lh.
- Error conditions:
  - funct3 is 011, 110 or 111.
  - A store with funct3 100 or 101.
  - `req_addr + size > DEPTH`, computed 33 bits wide with size 1, 2 or 4. For example, `DEPTH-2` with lw is an error; `DEPTH-1` with lb is legal.
- On error: no write enable is asserted, `rsp_rdata=0`, `rsp_err=1`.
- Alignment is not checked; `dmem` is byte-addressed.

## Timing
- Reset values: state IDLE, `req_ready=0` while `rst_n` is low, `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`, `mem_addr=0`, `mem_din=0`, all `mem_we*=0`.
- Write enables are decoded from the registered state and gated by `rst_n`. Reset asserted during ACCESS therefore performs no write.
- Latency: request accepted at edge N, ACCESS during cycle N..N+1, `rsp_valid` high after edge N+1.
- Peak throughput: one access per 2 cycles, with back-to-back accept in RESP.
- A store's write commits at the edge that ends ACCESS. A following load's ACCESS is at least one cycle later, so it sees the new data. No forwarding is needed.
- Outside ACCESS, `mem_addr` and `mem_din` hold their last values and the write enables are 0.

## Structure
- `lsu_pkg` holds:
  - `state_t` enum (IDLE, ACCESS, RESP);
  - funct3 localparams (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`);
  - function `access_size(funct3)` returning 1, 2 or 4.
- One combinational sub-module, `lsu_align`: funct3 + wdata → `mem_din` + write enables, and funct3 + `mem_dout` → extended rdata. The FSM and registers stay in `lsu`.

## Test plan
- sw 0xDEADBEEF at addr 0x10, then lw 0x10 → `mem_we0..2` high for exactly one cycle, `mem_din=0xDEADBEEF`; load returns 0xDEADBEEF, `rsp_err=0`.
- sb 0x1234_5680 at 0x21, then lb 0x21 and lbu 0x21 → only `we0`, `mem_din=0x80000000`; lb returns 0xFFFFFF80, lbu returns 0x00000080.
- sh 0x0000_8001 at 0x30, then lh and lhu 0x30 → `we0` and `we1` only; lh returns 0xFFFF8001, lhu returns 0x00008001.
- lw at `DEPTH-2`; store with funct3 101 → no write enable, `rsp_err=1`, `rsp_rdata=0`. lb at `DEPTH-1` → `rsp_err=0`.
- `rsp_ready` held low for 5 cycles with `req_valid` high → `rsp_*` stable and `req_ready=0`; on release the next request is accepted in the same cycle.
- `rst_n` pulsed low during the ACCESS of a store → no write; the memory byte is unchanged on readback; `rsp_valid=0` after reset.
